mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one 64-bit memory port between the instruction-fetch requester (imem_*) and the
//  load/store requester (dmem_*). Data side wins ties; optional anti-starvation forces a fetch
//  grant after a data streak. One transaction outstanding; response routed to owning requester.
// PARAMETERS
//  ADDR_W       64  address width, all ports
//  DATA_W       64  data width, all ports
//  MAX_DSTREAK  4   consecutive data grants before a waiting fetch is forced (MEM_ARB_FAIR_EN), >=1
// PORTS
//  clk              in   1       clock; all logic on posedge
//  rst              in   1       reset, synchronous, active-high
//  imem_addr        in   ADDR_W  fetch address
//  imem_addr_valid  in   1       fetch request
//  imem_flush       in   1       discard outstanding fetch response (jump taken)
//  imem_data        out  DATA_W  fetch read data
//  imem_data_valid  out  1       fetch response strobe, 1 cycle
//  dmem_addr        in   ADDR_W  load/store address
//  dmem_addr_valid  in   1       load/store request
//  dmem_we          in   1       1=store, 0=load
//  dmem_wdata       in   DATA_W  store data
//  dmem_data        out  DATA_W  load data
//  dmem_data_valid  out  1       load/store completion strobe, 1 cycle
//  mem_addr         out  ADDR_W  shared port address (registered)
//  mem_req          out  1       shared port request (registered)
//  mem_we           out  1       shared port write enable (registered)
//  mem_wdata        out  DATA_W  shared port write data (registered)
//  mem_rdata        in   DATA_W  shared port read data
//  mem_ready        in   1       shared port completion, valid only while mem_req=1
// BEHAVIOUR
//  - Reset: state=IDLE; mem_req,mem_we,imem_data_valid,dmem_data_valid=0; mem_addr,mem_wdata=0;
//    streak=0; drop=0. Reset mid-transaction abandons it: no response strobe issued.
//  - FSM IDLE/IBUSY/DBUSY. IDLE: dmem_addr_valid -> DBUSY, else imem_addr_valid -> IBUSY.
//    Fairness override (MEM_ARB_FAIR_EN) wins over dmem. On grant, next edge registers
//    mem_addr/mem_we/mem_wdata from the winner, mem_req=1; mem_we=0 for fetch grants.
//  - BUSY: mem_req,mem_addr,mem_we,mem_wdata held stable until mem_ready=1. In the mem_ready
//    cycle: owner's *_data_valid=1 combinationally, *_data=mem_rdata; next edge mem_req=0, IDLE.
//  - Min latency: request in IDLE at cycle N -> mem_req=1 in N+1 -> earliest valid N+1
//    (mem_ready same cycle). One IDLE cycle between transactions; max 1 txn per 2 cycles.
//  - imem_data/dmem_data = mem_rdata always; only the strobes are gated.
//  - Requesters hold addr/valid (and we/wdata) until their data_valid; values sampled at grant
//    only; later changes do not affect the outstanding transaction.
//  - imem_flush while IBUSY (incl. the mem_ready cycle) sets drop; response completes on the
//    port but imem_data_valid stays 0. drop clears on return to IDLE. Flush in IDLE/DBUSY: no-op.
//  - Store completion pulses dmem_data_valid; dmem_data undefined for stores.
//  - mem_ready while mem_req=0 is ignored.
// CONFIGURATION
//  MEM_ARB_FAIR_EN defined: streak counter ($clog2(MAX_DSTREAK+1) bits) +1 per data grant
//    made while imem_addr_valid=1, saturating at MAX_DSTREAK; cleared on any fetch grant.
//    In IDLE with streak==MAX_DSTREAK and imem_addr_valid=1, fetch is granted regardless of dmem.
//  MEM_ARB_FAIR_EN undefined: no counter; strict data priority (fetch may starve).
// TESTING
//  1 rst=1 3 cycles, both valid -> all strobes/mem_req 0; rst release -> DBUSY, mem_req=1 next cycle.
//  2 imem only, addr=0x100, mem_ready=1 after 2 cycles, rdata=0xDEAD -> imem_data_valid 1 cycle,
//    imem_data=0xDEAD, mem_we=0; dmem_data_valid never 1.
//  3 both valid, dmem store addr=0x40 wdata=0x55 -> mem_we=1,mem_addr=0x40,mem_wdata=0x55 first;
//    fetch granted after dmem_data_valid pulse and one IDLE cycle.
//  4 FAIR_EN, MAX_DSTREAK=4, dmem and imem valid continuously -> grant order D,D,D,D,I,D,...;
//    without macro -> only D grants.
//  5 imem_flush pulse during IBUSY -> mem_ready completes, imem_data_valid stays 0; next fetch
//    at 0x200 returns normally with valid.
//  6 rst asserted while DBUSY before mem_ready -> no dmem_data_valid; mem_req=0 after edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (imem_*) and load/store (dmem_*).
// The data side wins ties. Only one transaction can be outstanding at a time, and its response
// is routed back to the requester that owns it.
// Optional feature macro MEM_ARB_FAIR_EN: after MAX_DSTREAK consecutive data grants made while a
// fetch was waiting, the next grant is forced to the fetch side.
module mem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_addr_valid,
  input  logic              imem_flush,
  output logic [DATA_W-1:0] imem_data,
  output logic              imem_data_valid,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_addr_valid,
  input  logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_wdata,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_data_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, IBUSY = 2'd1, DBUSY = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                grant_i, grant_d;
  logic                fair_force;
  logic                drop_q, drop_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                done;

  // A completion only counts while a request is actually on the port
  assign done = mem_req_q && mem_ready;

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  logic [SW-1:0] streak_q, streak_d;

  assign fair_force = imem_addr_valid && (streak_q == STREAK_MAX);

  // Count data grants that overtook a waiting fetch; any fetch grant restarts the streak
  always_comb begin
    streak_d = streak_q;
    if (grant_i) begin
      streak_d = '0;
    end else if (grant_d && imem_addr_valid && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Streak counter register
  always_ff @(posedge clk) begin
    if (rst) streak_q <= '0;
    else     streak_q <= streak_d;
  end
`else
  // Strict data priority: the streak limit has no effect in this build
  logic unused_max_dstreak;
  assign unused_max_dstreak = ^(32'(MAX_DSTREAK));
  assign fair_force = 1'b0;
`endif

  // Next-state: arbitrate in IDLE, wait for the port to complete while busy
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fair_force) begin
          grant_i = 1'b1;
          state_d = IBUSY;
        end else if (dmem_addr_valid) begin
          grant_d = 1'b1;
          state_d = DBUSY;
        end else if (imem_addr_valid) begin
          grant_i = 1'b1;
          state_d = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Port request fields are captured from the winner at grant and held until completion;
  // a flushed fetch keeps running on the port but its response is dropped
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    mem_req_d   = (state_d != IDLE);
    if (grant_d) begin
      mem_addr_d  = dmem_addr;
      mem_we_d    = dmem_we;
      mem_wdata_d = dmem_wdata;
    end else if (grant_i) begin
      mem_addr_d  = imem_addr;
      mem_we_d    = 1'b0;
    end
    drop_d = (state_q == IBUSY && state_d == IBUSY) ? (drop_q | imem_flush) : 1'b0;
  end

  // State and port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Response strobes: route completion to the owner; a reset in the completion cycle abandons it
  always_comb begin
    imem_data_valid = 1'b0;
    dmem_data_valid = 1'b0;
    if (!rst && done) begin
      if (state_q == IBUSY) imem_data_valid = !drop_q && !imem_flush;
      if (state_q == DBUSY) dmem_data_valid = 1'b1;
    end
  end

  assign imem_data = mem_rdata;
  assign dmem_data = mem_rdata;
  assign mem_addr  = mem_addr_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: cycle-by-cycle vector table for mem_arbiter plus a grant-order sequence
// whose expectation depends on MEM_ARB_FAIR_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic        imem_addr_valid;
  logic        imem_flush;
  logic [63:0] imem_data;
  logic        imem_data_valid;
  logic [63:0] dmem_addr;
  logic        dmem_addr_valid;
  logic        dmem_we;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_data;
  logic        dmem_data_valid;
  logic [63:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_DSTREAK(4)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_addr_valid(imem_addr_valid), .imem_flush(imem_flush),
    .imem_data(imem_data), .imem_data_valid(imem_data_valid),
    .dmem_addr(dmem_addr), .dmem_addr_valid(dmem_addr_valid), .dmem_we(dmem_we),
    .dmem_wdata(dmem_wdata), .dmem_data(dmem_data), .dmem_data_valid(dmem_data_valid),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // One row = inputs driven for one cycle and the outputs expected during that cycle
  typedef struct {
    logic        rst, iv;
    logic [63:0] ia;
    logic        dv;
    logic [63:0] da;
    logic        dwe;
    logic [63:0] dwd;
    logic        fl, rdy;
    logic [63:0] rd;
    logic        e_req, chk_bus, e_we;
    logic [63:0] e_addr, e_wd;
    logic        e_iv, e_dv;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic iv, logic [63:0] ia, logic dv, logic [63:0] da,
                              logic dwe, logic [63:0] dwd, logic fl, logic rdy, logic [63:0] rd,
                              logic e_req, logic chk_bus, logic e_we, logic [63:0] e_addr,
                              logic [63:0] e_wd, logic e_iv, logic e_dv);
    vec_t v;
    v.rst = r; v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dwe = dwe; v.dwd = dwd;
    v.fl = fl; v.rdy = rdy; v.rd = rd; v.e_req = e_req; v.chk_bus = chk_bus; v.e_we = e_we;
    v.e_addr = e_addr; v.e_wd = e_wd; v.e_iv = e_iv; v.e_dv = e_dv;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; imem_addr = '0; imem_addr_valid = 1'b0; imem_flush = 1'b0;
    dmem_addr = '0; dmem_addr_valid = 1'b0; dmem_we = 1'b0; dmem_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;

    //            rst iv ia     dv da    we wd   fl rdy rd       req bus we addr   wd   iv dv
    // reset held with both requesting; ready ignored
    vq.push_back(mk(1, 1, 'h100, 1, 'h40, 1, 'h55, 0, 0, 0,       0, 1, 0, 'h0,   'h0, 0, 0));
    vq.push_back(mk(1, 1, 'h100, 1, 'h40, 1, 'h55, 0, 1, 0,       0, 1, 0, 'h0,   'h0, 0, 0));
    vq.push_back(mk(0, 1, 'h100, 1, 'h40, 1, 'h55, 0, 0, 0,       0, 1, 0, 'h0,   'h0, 0, 0));
    // data wins the tie: store on the port
    vq.push_back(mk(0, 1, 'h100, 1, 'h40, 1, 'h55, 0, 0, 0,       1, 1, 1, 'h40,  'h55, 0, 0));
    vq.push_back(mk(0, 1, 'h100, 1, 'h40, 1, 'h55, 0, 1, 'hAAAA,  1, 1, 1, 'h40,  'h55, 0, 1));
    // one idle cycle, then the fetch at 0x100 completes after two wait cycles
    vq.push_back(mk(0, 1, 'h100, 0, 'h40, 1, 'h55, 0, 0, 0,       0, 0, 0, 'h0,   'h0, 0, 0));
    vq.push_back(mk(0, 1, 'h100, 0, 'h0,  0, 'h0,  0, 0, 0,       1, 1, 0, 'h100, 'h0, 0, 0));
    vq.push_back(mk(0, 1, 'h100, 0, 'h0,  0, 'h0,  0, 0, 0,       1, 1, 0, 'h100, 'h0, 0, 0));
    vq.push_back(mk(0, 1, 'h100, 0, 'h0,  0, 'h0,  0, 1, 'hDEAD,  1, 1, 0, 'h100, 'h0, 1, 0));
    vq.push_back(mk(0, 0, 'h0,   0, 'h0,  0, 'h0,  0, 0, 0,       0, 0, 0, 'h0,   'h0, 0, 0));
    // flush during a fetch: response dropped, next fetch at 0x200 returns normally
    vq.push_back(mk(0, 1, 'h180, 0, 'h0,  0, 'h0,  0, 0, 0,       0, 0, 0, 'h0,   'h0, 0, 0));
    vq.push_back(mk(0, 1, 'h180, 0, 'h0,  0, 'h0,  1, 0, 0,       1, 1, 0, 'h180, 'h0, 0, 0));
    vq.push_back(mk(0, 1, 'h180, 0, 'h0,  0, 'h0,  0, 1, 'hBEEF,  1, 1, 0, 'h180, 'h0, 0, 0));
    vq.push_back(mk(0, 1, 'h200, 0, 'h0,  0, 'h0,  0, 0, 0,       0, 0, 0, 'h0,   'h0, 0, 0));
    vq.push_back(mk(0, 1, 'h200, 0, 'h0,  0, 'h0,  0, 1, 'h1234,  1, 1, 0, 'h200, 'h0, 1, 0));
    // flush in the completion cycle itself suppresses the strobe
    vq.push_back(mk(0, 1, 'h208, 0, 'h0,  0, 'h0,  0, 0, 0,       0, 0, 0, 'h0,   'h0, 0, 0));
    vq.push_back(mk(0, 1, 'h208, 0, 'h0,  0, 'h0,  1, 1, 'h77,    1, 1, 0, 'h208, 'h0, 0, 0));
    // ready with no request is ignored
    vq.push_back(mk(0, 0, 'h0,   0, 'h0,  0, 'h0,  0, 1, 'h5,     0, 0, 0, 'h0,   'h0, 0, 0));
    // load at 0x48 with zero wait cycles
    vq.push_back(mk(0, 0, 'h0,   1, 'h48, 0, 'h0,  0, 0, 0,       0, 0, 0, 'h0,   'h0, 0, 0));
    vq.push_back(mk(0, 0, 'h0,   1, 'h48, 0, 'h0,  0, 1, 'hCAFE,  1, 1, 0, 'h48,  'h0, 0, 1));
    vq.push_back(mk(0, 0, 'h0,   0, 'h0,  0, 'h0,  0, 0, 0,       0, 0, 0, 'h0,   'h0, 0, 0));
    // reset while a store is outstanding: no completion strobe, port cleared
    vq.push_back(mk(0, 0, 'h0,   1, 'h50, 1, 'h9,  0, 0, 0,       0, 0, 0, 'h0,   'h0, 0, 0));
    vq.push_back(mk(1, 0, 'h0,   1, 'h50, 1, 'h9,  0, 0, 0,       1, 1, 1, 'h50,  'h9, 0, 0));
    vq.push_back(mk(0, 0, 'h0,   0, 'h0,  0, 'h0,  0, 1, 'h3,     0, 1, 0, 'h0,   'h0, 0, 0));

    repeat (2) tick();

    for (int i = 0; i < vq.size(); i++) begin
      tick();
      rst = vq[i].rst; imem_addr_valid = vq[i].iv; imem_addr = vq[i].ia;
      dmem_addr_valid = vq[i].dv; dmem_addr = vq[i].da; dmem_we = vq[i].dwe;
      dmem_wdata = vq[i].dwd; imem_flush = vq[i].fl; mem_ready = vq[i].rdy;
      mem_rdata = vq[i].rd;
      #2;
      check($sformatf("v%0d mem_req", i), 64'(mem_req), 64'(vq[i].e_req));
      check($sformatf("v%0d imem_data_valid", i), 64'(imem_data_valid), 64'(vq[i].e_iv));
      check($sformatf("v%0d dmem_data_valid", i), 64'(dmem_data_valid), 64'(vq[i].e_dv));
      if (vq[i].chk_bus) begin
        check($sformatf("v%0d mem_addr", i), mem_addr, vq[i].e_addr);
        check($sformatf("v%0d mem_we", i), 64'(mem_we), 64'(vq[i].e_we));
        if (vq[i].e_we) check($sformatf("v%0d mem_wdata", i), mem_wdata, vq[i].e_wd);
      end
      if (vq[i].e_iv) check($sformatf("v%0d imem_data", i), imem_data, vq[i].rd);
      if (vq[i].e_dv && !vq[i].dwe) check($sformatf("v%0d dmem_data", i), dmem_data, vq[i].rd);
      $display("vec %0d: req=%0b addr=0x%0h we=%0b iv=%0b dv=%0b", i, mem_req, mem_addr,
               mem_we, imem_data_valid, dmem_data_valid);
    end

    // Both requesters valid continuously: record the grant order
    tick();
    rst = 1'b0; imem_addr_valid = 1'b1; imem_addr = 64'h300; imem_flush = 1'b0;
    dmem_addr_valid = 1'b1; dmem_addr = 64'h400; dmem_we = 1'b0; dmem_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    #2;
    check("streak idle mem_req", 64'(mem_req), 64'd0);
    for (int g = 0; g < 10; g++) begin
      logic exp_fetch;
`ifdef MEM_ARB_FAIR_EN
      exp_fetch = ((g % 5) == 4);
`else
      exp_fetch = 1'b0;
`endif
      tick();
      mem_ready = 1'b1; mem_rdata = 64'(g + 16);
      #2;
      check($sformatf("grant%0d mem_req", g), 64'(mem_req), 64'd1);
      check($sformatf("grant%0d mem_addr", g), mem_addr, exp_fetch ? 64'h300 : 64'h400);
      check($sformatf("grant%0d imem_data_valid", g), 64'(imem_data_valid), 64'(exp_fetch));
      check($sformatf("grant%0d dmem_data_valid", g), 64'(dmem_data_valid), 64'(!exp_fetch));
      $display("grant %0d: %s addr=0x%0h", g, imem_data_valid ? "I" : "D", mem_addr);
      tick();
      mem_ready = 1'b0;
      #2;
      check($sformatf("grant%0d idle mem_req", g), 64'(mem_req), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
